// File: rtl/aes_round_sequencer.sv
// Iterative round controller for a redundant-representation AES core: holds the
// cipher state, sequences round-key requests and folds each key into the round result.
module aes_round_sequencer #(
  parameter int unsigned d  = 0,
  parameter int unsigned NR = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [3:0][3:0][0:7+d] state_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [3:0][3:0][0:7+d] state_o,
  output logic                   key_req_o,
  output logic [3:0]             key_idx_o,
  input  logic                   key_valid_i,
  input  logic [3:0][3:0][0:7+d] key_i,
  output logic [3:0][3:0][0:7+d] rnd_state_o,
  output logic                   rnd_last_o,
  input  logic [3:0][3:0][0:7+d] rnd_state_i,
  output logic [3:0]             round_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEY0  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  fsm_e                   fsm_q, fsm_d;
  logic [3:0][3:0][0:7+d] state_q, state_d;
  logic [3:0]             round_q, round_d;
  logic                   last_round;

  assign last_round = (round_q == 4'(NR));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    round_d     = round_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    key_req_o   = 1'b0;
    key_idx_o   = '0;
    rnd_last_o  = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          state_d = state_i;
          round_d = '0;
          fsm_d   = KEY0;
        end
      end
      KEY0: begin
        // Initial whitening key; no round datapath involvement.
        key_req_o = 1'b1;
        if (key_valid_i) begin
          state_d = state_q ^ key_i;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        key_req_o  = 1'b1;
        key_idx_o  = round_q;
        rnd_last_o = last_round;
        if (key_valid_i) begin
          state_d = rnd_state_i ^ key_i;
          if (last_round) begin
            fsm_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign state_o     = state_q;
  assign rnd_state_o = state_q;
  assign round_o     = round_q;
  assign busy_o      = (fsm_q != IDLE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: an AES-128 reference datapath/key schedule
// drives a d=0 instance, and a linear toy datapath drives a d=8 instance.
module tb_aes_round_sequencer;
  localparam int NR = 10;
  typedef logic [3:0][3:0][0:7]  st0_t;
  typedef logic [3:0][3:0][0:15] st8_t;
  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic iv0, ir0, ov0, or0, kr0, kv0, last0, busy0;
  logic [3:0] kidx0, rnd0;
  st0_t si0, so0, ki0, rso0, rsi0;

  logic iv8, ir8, ov8, or8, kr8, kv8, last8, busy8;
  logic [3:0] kidx8, rnd8;
  st8_t si8, so8, ki8, rso8, rsi8;

  logic [7:0]   sbox [256];
  logic [127:0] rk   [0:10];
  vec_t         tbl  [3];
  int checks = 0;
  int errors = 0;

  aes_round_sequencer #(.d(0), .NR(NR)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv0), .in_ready_o(ir0), .state_i(si0),
    .out_valid_o(ov0), .out_ready_i(or0), .state_o(so0), .key_req_o(kr0),
    .key_idx_o(kidx0), .key_valid_i(kv0), .key_i(ki0), .rnd_state_o(rso0),
    .rnd_last_o(last0), .rnd_state_i(rsi0), .round_o(rnd0), .busy_o(busy0)
  );

  aes_round_sequencer #(.d(8), .NR(NR)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv8), .in_ready_o(ir8), .state_i(si8),
    .out_valid_o(ov8), .out_ready_i(or8), .state_o(so8), .key_req_o(kr8),
    .key_idx_o(kidx8), .key_valid_i(kv8), .key_i(ki8), .rnd_state_o(rso8),
    .rnd_last_o(last8), .rnd_state_i(rsi8), .round_o(rnd8), .busy_o(busy8)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Byte n of a FIPS-197 vector sits at row n%4, column n/4.
  function automatic st0_t to_st0(input logic [127:0] v);
    st0_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = v[127-8*(r+4*c) -: 8];
    return s;
  endfunction

  function automatic logic [127:0] from_st0(input st0_t s);
    logic [127:0] v;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) v[127-8*(r+4*c) -: 8] = s[r][c];
    return v;
  endfunction

  function automatic logic [127:0] aes_rnd(input logic [127:0] v, input logic last);
    logic [7:0] b [16];
    logic [7:0] s [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox[v[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
        s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic st8_t rnd8_f(input st8_t v, input logic last);
    st8_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[r][c] = v[r][(c+r)%4] ^ (last ? 16'h00ff : 16'h0000);
    return o;
  endfunction

  function automatic st8_t key8(input int idx);
    st8_t k;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) k[r][c] = 16'(idx * 16'h0931 + r * 16'h0107 + c * 16'h0025) ^ 16'ha55a;
    return k;
  endfunction

  function automatic st8_t model8(input st8_t p);
    st8_t s = p ^ key8(0);
    for (int i = 1; i <= NR; i++) s = rnd8_f(s, i == NR) ^ key8(i);
    return s;
  endfunction

  always_comb begin
    rsi0 = to_st0(aes_rnd(from_st0(rso0), last0));
    ki0  = (kidx0 <= 4'd10) ? to_st0(rk[kidx0]) : '0;
    rsi8 = rnd8_f(rso8, last8);
    ki8  = key8(int'(kidx8));
  end

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= 10; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run0(input vec_t v, output logic [127:0] ct, output int lat);
    expand(v.key);
    si0 = to_st0(v.pt);
    iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    lat = 1;
    while (!ov0 && lat < 60) begin tick(); lat++; end
    ct = from_st0(so0);
    or0 = 1'b1;
    tick();
    or0 = 1'b0;
  endtask

  initial begin
    logic [127:0] ct;
    int n, s0, s7;
    logic stall;
    st8_t p8, res8, hs;
    logic [3:0] hr;

    rst_n = 1'b0;
    iv0 = 0; or0 = 0; kv0 = 1; si0 = '0;
    iv8 = 0; or8 = 0; kv8 = 1; si8 = '0;
    build_sbox();
    tbl[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tbl[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3925841d02dc09fbdc118597196a0b32};
    tbl[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    tick(); tick();
    chk("rst_in_ready", ir0, 1); chk("rst_out_valid", ov0, 0); chk("rst_key_req", kr0, 0);
    chk("rst_key_idx", kidx0, 0); chk("rst_last", last0, 0); chk("rst_busy", busy0, 0);
    chk("rst_round", rnd0, 0); chk("rst_state", from_st0(so0), 0);
    rst_n = 1'b1;
    tick();

    // Known-answer vectors with unstalled keys.
    for (int i = 0; i < 3; i++) begin
      run0(tbl[i], ct, n);
      chk("kat_ct", ct, tbl[i].ct);
      chk("kat_latency", n, 12);
    end

    // Key index ordering and last-round flag.
    expand(tbl[0].key);
    si0 = to_st0(tbl[0].pt);
    iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      chk("ord_key_req", kr0, 1);
      chk("ord_key_idx", kidx0, k - 1);
      chk("ord_last", last0, k == 11);
      chk("ord_out_valid_early", ov0, 0);
      tick();
    end
    chk("ord_out_valid_12", ov0, 1);
    chk("ord_key_req_done", kr0, 0);
    chk("ord_ct", from_st0(so0), tbl[0].ct);
    or0 = 1'b1; tick(); or0 = 1'b0;

    // Reset mid-ROUND at round 5.
    expand(tbl[1].key);
    si0 = to_st0(tbl[1].pt);
    iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    n = 0;
    while (rnd0 != 4'd5 && n < 20) begin tick(); n++; end
    chk("mid_round5", rnd0, 5);
    chk("mid_busy", busy0, 1);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("mrst_in_ready", ir0, 1); chk("mrst_out_valid", ov0, 0); chk("mrst_key_req", kr0, 0);
    chk("mrst_round", rnd0, 0); chk("mrst_busy", busy0, 0);
    tick();
    chk("mrst_no_output", ov0, 0);
    run0(tbl[0], ct, n);
    chk("mrst_next_ct", ct, tbl[0].ct);
    chk("mrst_next_latency", n, 12);

    // Output backpressure with in_valid held high.
    expand(tbl[0].key);
    si0 = to_st0(tbl[0].pt);
    iv0 = 1'b1;
    tick();
    si0 = to_st0(tbl[1].pt);
    n = 1;
    while (!ov0 && n < 60) begin tick(); n++; end
    chk("bp_latency", n, 12);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", from_st0(so0), tbl[0].ct);
      chk("bp_in_ready", ir0, 0);
      chk("bp_out_valid", ov0, 1);
      tick();
    end
    or0 = 1'b1;
    tick();
    chk("bp_idle_ready", ir0, 1);
    chk("bp_idle_valid", ov0, 0);
    expand(tbl[1].key);
    or0 = 1'b0;
    tick();
    iv0 = 1'b0;
    chk("bp_accept_busy", busy0, 1);
    chk("bp_accept_key0", kr0, 1);
    n = 1;
    while (!ov0 && n < 60) begin tick(); n++; end
    chk("bp_second_latency", n, 12);
    chk("bp_second_ct", from_st0(so0), tbl[1].ct);
    or0 = 1'b1; tick(); or0 = 1'b0;

    // Back-to-back blocks.
    or0 = 1'b1;
    iv0 = 1'b1;
    for (int b = 0; b < 3; b++) begin
      expand(tbl[b].key);
      si0 = to_st0(tbl[b].pt);
      chk("b2b_in_ready", ir0, 1);
      tick();
      n = 1;
      while (!ov0 && n < 60) begin tick(); n++; end
      chk("b2b_latency", n, 12);
      chk("b2b_ct", from_st0(so0), tbl[b].ct);
      tick();
    end
    iv0 = 1'b0;
    or0 = 1'b0;

    // d=8 instance: reference run, then stalled run.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) p8[r][c] = 16'((r * 4 + c + 1) * 16'h1357);
    si8 = p8;
    iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    n = 1;
    while (!ov8 && n < 60) begin tick(); n++; end
    chk("d8_latency", n, 12);
    chk("d8_result", so8, model8(p8));
    res8 = so8;
    or8 = 1'b1; tick(); or8 = 1'b0;

    iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    n = 1; s0 = 0; s7 = 0;
    while (!ov8 && n < 60) begin
      stall = 1'b0;
      if (kr8 && kidx8 == 4'd0 && s0 < 3) begin stall = 1'b1; s0++; end
      else if (kr8 && kidx8 == 4'd7 && s7 < 2) begin stall = 1'b1; s7++; end
      kv8 = !stall;
      hs = so8;
      hr = rnd8;
      tick();
      n++;
      if (stall) begin
        chk("d8_stall_state", so8, hs);
        chk("d8_stall_round", rnd8, hr);
      end
    end
    kv8 = 1'b1;
    chk("d8_stall_latency", n, 17);
    chk("d8_stall_result", so8, res8);
    chk("d8_stall_model", so8, model8(p8));
    or8 = 1'b1; tick(); or8 = 1'b0;
    chk("d8_idle", busy8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
